// File: rtl/fifo_ctrl_if.sv
// Handshake and status bundle between a FIFO pointer/flag controller and its
// producer/consumer side. The slave modport is the controller's view.
interface fifo_ctrl_if #(
  parameter int PTR_L = 2
);
  logic             wr_req;
  logic             rd_req;
  logic [PTR_L:0]   af_th;
  logic [PTR_L:0]   ae_th;
  logic             push;
  logic             pop;
  logic [PTR_L-1:0] wr_ptr;
  logic [PTR_L-1:0] rd_ptr;
  logic [PTR_L:0]   fifo_count;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic             rd_valid;
  logic             overflow_err;
  logic             underflow_err;

  modport master (
    output wr_req, rd_req, af_th, ae_th,
    input  push, pop, wr_ptr, rd_ptr, fifo_count, full, empty,
           almost_full, almost_empty, rd_valid, overflow_err, underflow_err
  );

  modport slave (
    input  wr_req, rd_req, af_th, ae_th,
    output push, pop, wr_ptr, rd_ptr, fifo_count, full, empty,
           almost_full, almost_empty, rd_valid, overflow_err, underflow_err
  );
endinterface

// File: rtl/fifo_ctrl.sv
// FIFO pointer and flag controller: push/pop strobes, wrapping addresses,
// occupancy count, threshold flags, sticky error flags and read-valid alignment.
module fifo_ctrl #(
  parameter int MEM_SIZE = 4,
  parameter int PTR_L    = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  fifo_ctrl_if.slave  bus
);
  localparam int CNT_W = PTR_L + 1;

  logic [PTR_L-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_L-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rd_valid_q, rd_valid_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             full_s, empty_s;
  logic             push_s, pop_s;

  assign full_s  = (count_q == CNT_W'(MEM_SIZE));
  assign empty_s = (count_q == {CNT_W{1'b0}});

  // Strobes; a write into a full FIFO is admitted only alongside a read.
  always_comb begin
    pop_s  = 1'b0;
    push_s = 1'b0;
    if (reset_i) begin
      pop_s  = 1'b0;
      push_s = 1'b0;
    end else begin
      pop_s  = bus.rd_req & ~empty_s;
      push_s = bus.wr_req & (~full_s | pop_s);
    end
  end

  // Next-state for pointers, occupancy, read-valid and sticky errors.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = pop_s;
    ovf_d      = ovf_q | (bus.wr_req & full_s & ~pop_s);
    udf_d      = udf_q | (bus.rd_req & empty_s);
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_L'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_L'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= {PTR_L{1'b0}};
      rd_ptr_q   <= {PTR_L{1'b0}};
      count_q    <= {CNT_W{1'b0}};
      rd_valid_q <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
    end
  end

  assign bus.push          = push_s;
  assign bus.pop           = pop_s;
  assign bus.wr_ptr        = wr_ptr_q;
  assign bus.rd_ptr        = rd_ptr_q;
  assign bus.fifo_count    = count_q;
  assign bus.full          = full_s;
  assign bus.empty         = empty_s;
  assign bus.almost_full   = (count_q >= bus.af_th);
  assign bus.almost_empty  = (count_q <= bus.ae_th);
  assign bus.rd_valid      = rd_valid_q;
  assign bus.overflow_err  = ovf_q;
  assign bus.underflow_err = udf_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl with MEM_SIZE=4.
module tb_fifo_ctrl;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  fifo_ctrl_if #(.PTR_L(2)) bus ();

  fifo_ctrl #(.MEM_SIZE(4), .PTR_L(2)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive request inputs away from the rising edge, then settle.
  task automatic drive(input logic rst, input logic wr, input logic rd);
    @(negedge clk);
    reset      = rst;
    bus.wr_req = wr;
    bus.rd_req = rd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.af_th  = 3'd3;
    bus.ae_th  = 3'd1;

    // Reset with a write request present: strobes must stay low.
    drive(1'b1, 1'b1, 1'b1);
    check_val("rst_push", 32'(bus.push), 0);
    check_val("rst_pop", 32'(bus.pop), 0);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    check_val("rst_cnt", 32'(bus.fifo_count), 0);
    check_val("rst_wp", 32'(bus.wr_ptr), 0);
    check_val("rst_rp", 32'(bus.rd_ptr), 0);
    check_val("rst_empty", 32'(bus.empty), 1);
    check_val("rst_full", 32'(bus.full), 0);
    check_val("rst_ae", 32'(bus.almost_empty), 1);
    check_val("rst_af", 32'(bus.almost_full), 0);
    check_val("rst_rv", 32'(bus.rd_valid), 0);
    check_val("rst_ovf", 32'(bus.overflow_err), 0);
    check_val("rst_udf", 32'(bus.underflow_err), 0);

    // Fill.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      check_val("fill_push", 32'(bus.push), 1);
      tick();
      check_val("fill_wp", 32'(bus.wr_ptr), i % 4);
      check_val("fill_cnt", 32'(bus.fifo_count), i);
      check_val("fill_full", 32'(bus.full), (i == 4) ? 1 : 0);
      check_val("fill_af", 32'(bus.almost_full), (i >= 3) ? 1 : 0);
      check_val("fill_ae", 32'(bus.almost_empty), (i <= 1) ? 1 : 0);
      check_val("fill_empty", 32'(bus.empty), 0);
    end

    // Overflow.
    drive(1'b0, 1'b1, 1'b0);
    check_val("ovf_push", 32'(bus.push), 0);
    tick();
    check_val("ovf_cnt", 32'(bus.fifo_count), 4);
    check_val("ovf_wp", 32'(bus.wr_ptr), 0);
    check_val("ovf_flag", 32'(bus.overflow_err), 1);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check_val("ovf_sticky", 32'(bus.overflow_err), 1);

    // Drain.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      check_val("drain_pop", 32'(bus.pop), 1);
      tick();
      check_val("drain_rp", 32'(bus.rd_ptr), i % 4);
      check_val("drain_cnt", 32'(bus.fifo_count), 4 - i);
      check_val("drain_rv", 32'(bus.rd_valid), 1);
      check_val("drain_empty", 32'(bus.empty), (i == 4) ? 1 : 0);
    end
    check_val("drain_udf0", 32'(bus.underflow_err), 0);
    drive(1'b0, 1'b0, 1'b1);
    check_val("udf_pop", 32'(bus.pop), 0);
    tick();
    check_val("udf_flag", 32'(bus.underflow_err), 1);
    check_val("udf_rv", 32'(bus.rd_valid), 0);
    check_val("udf_cnt", 32'(bus.fifo_count), 0);
    check_val("udf_rp", 32'(bus.rd_ptr), 0);

    // Simultaneous request at empty: write only, read flagged.
    do_reset();
    drive(1'b0, 1'b1, 1'b1);
    check_val("se_push", 32'(bus.push), 1);
    check_val("se_pop", 32'(bus.pop), 0);
    tick();
    check_val("se_cnt", 32'(bus.fifo_count), 1);
    check_val("se_udf", 32'(bus.underflow_err), 1);
    check_val("se_wp", 32'(bus.wr_ptr), 1);
    check_val("se_rp", 32'(bus.rd_ptr), 0);
    check_val("se_rv", 32'(bus.rd_valid), 0);

    // Top up to full, then simultaneous request at full.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    check_val("sf_pre_full", 32'(bus.full), 1);
    drive(1'b0, 1'b1, 1'b1);
    check_val("sf_push", 32'(bus.push), 1);
    check_val("sf_pop", 32'(bus.pop), 1);
    tick();
    check_val("sf_cnt", 32'(bus.fifo_count), 4);
    check_val("sf_ovf", 32'(bus.overflow_err), 0);
    check_val("sf_wp", 32'(bus.wr_ptr), 1);
    check_val("sf_rp", 32'(bus.rd_ptr), 1);
    check_val("sf_rv", 32'(bus.rd_valid), 1);

    // Streaming from count 2.
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b1, 1'b0);
      tick();
    end
    check_val("st_ae_lo", 32'(bus.almost_empty), 0);
    bus.ae_th = 3'd2;
    #1;
    check_val("st_ae_hi", 32'(bus.almost_empty), 1);
    bus.ae_th = 3'd1;
    for (int k = 1; k <= 20; k++) begin
      drive(1'b0, 1'b1, 1'b1);
      check_val("st_push", 32'(bus.push), 1);
      check_val("st_pop", 32'(bus.pop), 1);
      tick();
      check_val("st_cnt", 32'(bus.fifo_count), 2);
      check_val("st_wp", 32'(bus.wr_ptr), (2 + k) % 4);
      check_val("st_rp", 32'(bus.rd_ptr), k % 4);
      check_val("st_rv", 32'(bus.rd_valid), 1);
    end

    // Reset mid-stream at count 3.
    drive(1'b0, 1'b1, 1'b0);
    tick();
    check_val("mr_cnt3", 32'(bus.fifo_count), 3);
    drive(1'b0, 1'b1, 1'b1);
    tick();
    check_val("mr_rv_pre", 32'(bus.rd_valid), 1);
    drive(1'b1, 1'b1, 1'b1);
    check_val("mr_pop", 32'(bus.pop), 0);
    check_val("mr_push", 32'(bus.push), 0);
    tick();
    check_val("mr_cnt", 32'(bus.fifo_count), 0);
    check_val("mr_wp", 32'(bus.wr_ptr), 0);
    check_val("mr_rp", 32'(bus.rd_ptr), 0);
    check_val("mr_rv", 32'(bus.rd_valid), 0);
    check_val("mr_ovf", 32'(bus.overflow_err), 0);
    check_val("mr_udf", 32'(bus.underflow_err), 0);

    drive(1'b0, 1'b0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
